// File: rtl/scr1_memory_ahb_pkg.sv
// Shared AHB-Lite encodings, MMIO map and lane helpers for the SCR1 bench memory.
package scr1_memory_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam logic [31:0] MMIO_PRINT    = 32'hF000_0000;
  localparam logic [31:0] MMIO_IRQ      = 32'hF000_0100;
  localparam logic [31:0] MMIO_SOFT_IRQ = 32'hF000_0200;

  // Only NONSEQ and SEQ carry a transfer; IDLE and BUSY are ignored.
  function automatic logic f_is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

  // Little-endian byte lanes touched by a write of the given size/offset.
  function automatic logic [3:0] f_byte_en(input logic [2:0] size, input logic [1:0] offs);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << offs;
      HSIZE_HALF: be = offs[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/scr1_memory_ahb_stall.sv
// Per-port wait-state generator: a rotating pattern decides hready in data phases.
module scr1_memory_ahb_stall (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_stall_pattern,
  input  logic        i_dphase,
  output logic        o_hready
);

  logic [31:0] r_pattern;

  // The pattern keeps reloading while reset is held, then rotates freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= i_stall_pattern;
    end else begin
      r_pattern <= {r_pattern[0], r_pattern[31:1]};
    end
  end

  // Reset forces ready so no transfer is left stalled across it.
  assign o_hready = rst | ~i_dphase | (r_pattern == 32'd0) | r_pattern[0];

endmodule

// File: rtl/scr1_memory_ahb.sv
// AHB-Lite bench memory: shared byte array behind an imem (read) and dmem (r/w) port,
// with per-port wait states and console / interrupt MMIO registers on dmem.
// Handshake: an address phase is taken when htrans is NONSEQ/SEQ while hready=1;
// its data phase completes on the first following cycle with hready=1, and the
// master must hold its next address-phase signals unchanged while hready=0.
module scr1_memory_ahb
  import scr1_memory_ahb_pkg::*;
#(
  parameter int SCR1_MEM_POWER_SIZE = 20,
  parameter int SCR1_AHB_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               imem_req_ack_stall_in,
  input  logic [31:0]               dmem_req_ack_stall_in,
  input  logic [2:0]                imem_hsize,
  input  logic [1:0]                imem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
  output logic                      imem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
  output logic                      imem_hresp,
  input  logic [2:0]                dmem_hsize,
  input  logic [1:0]                dmem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
  input  logic                      dmem_hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
  output logic                      dmem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
  output logic                      dmem_hresp,
  output logic                      ext_irq,
  output logic                      soft_irq,
  output logic                      print_vld,
  output logic [7:0]                print_data
);

  localparam int P         = SCR1_MEM_POWER_SIZE;
  localparam int MEM_BYTES = 1 << P;

  logic [7:0] memory [0:MEM_BYTES-1];

  logic                      r_imem_dph;
  logic [P-3:0]              r_imem_widx;
  logic [SCR1_AHB_WIDTH-1:0] r_imem_hold;
  logic                      r_dmem_dph;
  logic [SCR1_AHB_WIDTH-1:0] r_dmem_addr;
  logic [2:0]                r_dmem_size;
  logic                      r_dmem_write;
  logic [SCR1_AHB_WIDTH-1:0] r_dmem_hold;
  logic                      r_ext_irq;
  logic                      r_soft_irq;
  logic                      r_print_vld;
  logic [7:0]                r_print_data;

  logic                      w_imem_acc;
  logic                      w_imem_done;
  logic [SCR1_AHB_WIDTH-1:0] w_imem_word;
  logic                      w_dmem_acc;
  logic                      w_dmem_done;
  logic                      w_dmem_rd_done;
  logic                      w_dmem_wr_done;
  logic                      w_dmem_mmio;
  logic [3:0]                w_dmem_be;
  logic [SCR1_AHB_WIDTH-1:0] w_dmem_word;
  logic                      w_unused;

  assign w_unused = ^{imem_hsize, imem_haddr[SCR1_AHB_WIDTH-1:P], imem_haddr[1:0]};

  scr1_memory_ahb_stall u_imem_stall (
    .clk             (clk),
    .rst             (rst),
    .i_stall_pattern (imem_req_ack_stall_in),
    .i_dphase        (r_imem_dph),
    .o_hready        (imem_hready)
  );

  scr1_memory_ahb_stall u_dmem_stall (
    .clk             (clk),
    .rst             (rst),
    .i_stall_pattern (dmem_req_ack_stall_in),
    .i_dphase        (r_dmem_dph),
    .o_hready        (dmem_hready)
  );

  assign w_imem_acc  = f_is_active(imem_htrans);
  assign w_dmem_acc  = f_is_active(dmem_htrans);

  // Completions are masked during reset so an aborted data phase never writes.
  assign w_imem_done    = r_imem_dph & imem_hready & ~rst;
  assign w_dmem_done    = r_dmem_dph & dmem_hready & ~rst;
  assign w_dmem_rd_done = w_dmem_done & ~r_dmem_write;
  assign w_dmem_wr_done = w_dmem_done & r_dmem_write;

  assign w_dmem_mmio = (r_dmem_addr == MMIO_PRINT) || (r_dmem_addr == MMIO_IRQ) ||
                       (r_dmem_addr == MMIO_SOFT_IRQ);
  assign w_dmem_be   = f_byte_en(r_dmem_size, r_dmem_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_dph  <= 1'b0;
      r_imem_widx <= '0;
    end else if (imem_hready) begin
      r_imem_dph <= w_imem_acc;
      if (w_imem_acc) begin
        r_imem_widx <= imem_haddr[P-1:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmem_dph   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_size  <= '0;
      r_dmem_write <= 1'b0;
    end else if (dmem_hready) begin
      r_dmem_dph <= w_dmem_acc;
      if (w_dmem_acc) begin
        r_dmem_addr  <= dmem_haddr;
        r_dmem_size  <= dmem_hsize;
        r_dmem_write <= dmem_hwrite;
      end
    end
  end

  // Array reads are combinational so a same-cycle write is seen only next cycle.
  always_comb begin
    w_imem_word = '0;
    for (int b = 0; b < 4; b++) begin
      w_imem_word[8*b +: 8] = memory[{r_imem_widx, 2'(b)}];
    end
  end

  always_comb begin
    w_dmem_word = '0;
    if (r_dmem_addr == MMIO_IRQ) begin
      w_dmem_word = {31'd0, r_ext_irq};
    end else if (r_dmem_addr == MMIO_SOFT_IRQ) begin
      w_dmem_word = {31'd0, r_soft_irq};
    end else if (r_dmem_addr != MMIO_PRINT) begin
      for (int b = 0; b < 4; b++) begin
        w_dmem_word[8*b +: 8] = memory[{r_dmem_addr[P-1:2], 2'(b)}];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_dmem_wr_done && !w_dmem_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (w_dmem_be[b]) begin
          memory[{r_dmem_addr[P-1:2], 2'(b)}] <= dmem_hwdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_imem_hold <= '0;
      r_dmem_hold <= '0;
    end else begin
      if (w_imem_done) begin
        r_imem_hold <= w_imem_word;
      end
      if (w_dmem_rd_done) begin
        r_dmem_hold <= w_dmem_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_irq    <= 1'b0;
      r_soft_irq   <= 1'b0;
      r_print_vld  <= 1'b0;
      r_print_data <= 8'd0;
    end else begin
      r_print_vld <= 1'b0;
      if (w_dmem_wr_done) begin
        case (r_dmem_addr)
          MMIO_PRINT: begin
            r_print_vld  <= 1'b1;
            r_print_data <= dmem_hwdata[7:0];
          end
          MMIO_IRQ:      r_ext_irq  <= dmem_hwdata[0];
          MMIO_SOFT_IRQ: r_soft_irq <= dmem_hwdata[0];
          default: ;
        endcase
      end
    end
  end

  assign imem_hrdata = w_imem_done    ? w_imem_word : r_imem_hold;
  assign dmem_hrdata = w_dmem_rd_done ? w_dmem_word : r_dmem_hold;
  assign imem_hresp  = HRESP_OKAY;
  assign dmem_hresp  = HRESP_OKAY;
  assign ext_irq     = r_ext_irq;
  assign soft_irq    = r_soft_irq;
  assign print_vld   = r_print_vld;
  assign print_data  = r_print_data;

endmodule

// File: tb/tb_scr1_memory_ahb.sv
// Directed bench for scr1_memory_ahb: pipelined reads, lane writes, wait states,
// MMIO side effects, address aliasing and reset abort of a stalled write.
module tb_scr1_memory_ahb;
  import scr1_memory_ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_req_ack_stall_in;
  logic [31:0] dmem_req_ack_stall_in;
  logic [2:0]  imem_hsize;
  logic [1:0]  imem_htrans;
  logic [31:0] imem_haddr;
  logic        imem_hready;
  logic [31:0] imem_hrdata;
  logic        imem_hresp;
  logic [2:0]  dmem_hsize;
  logic [1:0]  dmem_htrans;
  logic [31:0] dmem_haddr;
  logic        dmem_hwrite;
  logic [31:0] dmem_hwdata;
  logic        dmem_hready;
  logic [31:0] dmem_hrdata;
  logic        dmem_hresp;
  logic        ext_irq;
  logic        soft_irq;
  logic        print_vld;
  logic [7:0]  print_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          waits;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  scr1_memory_ahb dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem_req_ack_stall_in (imem_req_ack_stall_in),
    .dmem_req_ack_stall_in (dmem_req_ack_stall_in),
    .imem_hsize            (imem_hsize),
    .imem_htrans           (imem_htrans),
    .imem_haddr            (imem_haddr),
    .imem_hready           (imem_hready),
    .imem_hrdata           (imem_hrdata),
    .imem_hresp            (imem_hresp),
    .dmem_hsize            (dmem_hsize),
    .dmem_htrans           (dmem_htrans),
    .dmem_haddr            (dmem_haddr),
    .dmem_hwrite           (dmem_hwrite),
    .dmem_hwdata           (dmem_hwdata),
    .dmem_hready           (dmem_hready),
    .dmem_hrdata           (dmem_hrdata),
    .dmem_hresp            (dmem_hresp),
    .ext_irq               (ext_irq),
    .soft_irq              (soft_irq),
    .print_vld             (print_vld),
    .print_data            (print_data)
  );

  // ---------------- scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (inputs change 1 ns after posedge, sampled mid-cycle)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dmem_wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    tick();
    dmem_htrans = HTRANS_NONSEQ;
    dmem_hwrite = 1'b1;
    dmem_haddr  = a;
    dmem_hsize  = sz;
    tick();
    dmem_htrans = HTRANS_IDLE;
    dmem_hwrite = 1'b0;
    dmem_hwdata = d;
    #4;
  endtask

  task automatic dmem_rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    tick();
    dmem_htrans = HTRANS_NONSEQ;
    dmem_hwrite = 1'b0;
    dmem_haddr  = a;
    dmem_hsize  = HSIZE_WORD;
    tick();
    dmem_htrans = HTRANS_IDLE;
    #4;
    check({tag, "_rdy"}, 32'(dmem_hready), 32'd1);
    check(tag, dmem_hrdata, exp_q.pop_front());
  endtask

  task automatic imem_rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    tick();
    imem_htrans = HTRANS_NONSEQ;
    imem_haddr  = a;
    tick();
    imem_htrans = HTRANS_IDLE;
    #4;
    check(tag, imem_hrdata, exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    rst = 1'b1;
    imem_req_ack_stall_in = 32'd0;
    dmem_req_ack_stall_in = 32'd0;
    imem_hsize  = HSIZE_WORD;
    imem_htrans = HTRANS_IDLE;
    imem_haddr  = 32'd0;
    dmem_hsize  = HSIZE_WORD;
    dmem_htrans = HTRANS_IDLE;
    dmem_haddr  = 32'd0;
    dmem_hwrite = 1'b0;
    dmem_hwdata = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    #4;
    check("rst_imem_hready", 32'(imem_hready), 32'd1);
    check("rst_dmem_hready", 32'(dmem_hready), 32'd1);
    check("rst_imem_hrdata", imem_hrdata, 32'd0);
    check("rst_dmem_hrdata", dmem_hrdata, 32'd0);
    check("rst_hresp", {30'd0, imem_hresp, dmem_hresp}, 32'd0);
    check("rst_irqs", {30'd0, ext_irq, soft_irq}, 32'd0);
    check("rst_print_vld", 32'(print_vld), 32'd0);

    // Preload through the data port.
    dmem_wr(32'h200, HSIZE_WORD, 32'hDEAD_BEEF);
    dmem_wr(32'h204, HSIZE_WORD, 32'h0123_4567);
    dmem_wr(32'h100, HSIZE_WORD, 32'h1122_3344);
    dmem_wr(32'h300, HSIZE_WORD, 32'hCAFE_F00D);

    // Pipelined imem reads with zero wait states.
    tick();
    imem_htrans = HTRANS_NONSEQ;
    imem_haddr  = 32'h200;
    #4;
    check("imem_a0_rdy", 32'(imem_hready), 32'd1);
    tick();
    imem_htrans = HTRANS_SEQ;
    imem_haddr  = 32'h204;
    #4;
    check("imem_d0_rdy", 32'(imem_hready), 32'd1);
    check("imem_d0", imem_hrdata, 32'hDEAD_BEEF);
    tick();
    imem_htrans = HTRANS_IDLE;
    #4;
    check("imem_d1_rdy", 32'(imem_hready), 32'd1);
    check("imem_d1", imem_hrdata, 32'h0123_4567);
    tick();
    #4;
    check("imem_hold", imem_hrdata, 32'h0123_4567);

    // Lane writes, each immediately read back.
    dmem_wr(32'h103, HSIZE_BYTE, 32'hAB00_0000);
    dmem_rd_chk("byte_wr", 32'h100, 32'hAB22_3344);
    dmem_wr(32'h102, HSIZE_HALF, 32'hBEEF_0000);
    dmem_rd_chk("half_wr", 32'h100, 32'hBEEF_3344);
    dmem_wr(32'h101, HSIZE_BYTE, 32'h0000_5500);
    dmem_rd_chk("byte1_wr", 32'h100, 32'hBEEF_5544);

    // Addresses above the array size alias back into it.
    imem_rd_chk("imem_alias", 32'h0010_0200, 32'hDEAD_BEEF);
    dmem_rd_chk("dmem_alias", 32'h0010_0204, 32'h0123_4567);

    // imem read in the same cycle as a dmem write to the same word sees old data.
    tick();
    dmem_htrans = HTRANS_NONSEQ;
    dmem_hwrite = 1'b1;
    dmem_haddr  = 32'h300;
    dmem_hsize  = HSIZE_WORD;
    imem_htrans = HTRANS_NONSEQ;
    imem_haddr  = 32'h300;
    tick();
    dmem_htrans = HTRANS_IDLE;
    dmem_hwrite = 1'b0;
    dmem_hwdata = 32'h55AA_55AA;
    imem_htrans = HTRANS_IDLE;
    #4;
    check("same_cycle_old", imem_hrdata, 32'hCAFE_F00D);
    imem_rd_chk("same_cycle_new", 32'h300, 32'h55AA_55AA);

    // MMIO registers.
    dmem_wr(MMIO_IRQ, HSIZE_WORD, 32'd1);
    check("ext_irq_pre", 32'(ext_irq), 32'd0);
    tick();
    #4;
    check("ext_irq_rise", 32'(ext_irq), 32'd1);
    dmem_rd_chk("ext_irq_rd", MMIO_IRQ, 32'd1);
    dmem_wr(MMIO_IRQ, HSIZE_WORD, 32'd0);
    tick();
    #4;
    check("ext_irq_fall", 32'(ext_irq), 32'd0);
    dmem_wr(MMIO_SOFT_IRQ, HSIZE_WORD, 32'd1);
    check("soft_irq_pre", 32'(soft_irq), 32'd0);
    tick();
    #4;
    check("soft_irq_rise", 32'(soft_irq), 32'd1);
    dmem_rd_chk("soft_irq_rd", MMIO_SOFT_IRQ, 32'd1);
    dmem_wr(MMIO_SOFT_IRQ, HSIZE_WORD, 32'd0);
    tick();
    #4;
    check("soft_irq_fall", 32'(soft_irq), 32'd0);
    dmem_wr(MMIO_PRINT, HSIZE_WORD, 32'h0000_0041);
    check("print_pre", 32'(print_vld), 32'd0);
    tick();
    #4;
    check("print_vld", 32'(print_vld), 32'd1);
    check("print_data", 32'(print_data), 32'h41);
    tick();
    #4;
    check("print_once", 32'(print_vld), 32'd0);
    dmem_rd_chk("print_rd", MMIO_PRINT, 32'd0);
    dmem_wr(MMIO_IRQ, HSIZE_WORD, 32'd1);
    tick();

    // Wait states: pattern 5 gives data-phase hready 1,0,1,0,0,... after reset.
    rst = 1'b1;
    dmem_req_ack_stall_in = 32'h0000_0005;
    tick();
    tick();
    rst = 1'b0;
    dmem_htrans = HTRANS_NONSEQ;
    dmem_hwrite = 1'b1;
    dmem_haddr  = 32'h104;
    dmem_hsize  = HSIZE_WORD;
    #4;
    check("stall_rst_irq", 32'(ext_irq), 32'd0);
    check("stall_c0_rdy", 32'(dmem_hready), 32'd1);
    tick();
    dmem_hwdata = 32'h7766_5544;
    dmem_hwrite = 1'b0;
    dmem_haddr  = 32'h104;
    #4;
    check("stall_c1_rdy", 32'(dmem_hready), 32'd0);
    tick();
    #4;
    check("stall_c2_rdy", 32'(dmem_hready), 32'd1);
    tick();
    dmem_htrans = HTRANS_IDLE;
    #4;
    check("stall_c3_rdy", 32'(dmem_hready), 32'd0);
    check("stall_c3_hold", dmem_hrdata, 32'd0);
    waits = 0;
    while (!dmem_hready && waits < 40) begin
      tick();
      #4;
      waits++;
    end
    check("stall_waits", 32'(waits), 32'd29);
    check("stall_rd", dmem_hrdata, 32'h7766_5544);

    // Reset during a stalled write aborts it.
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    dmem_htrans = HTRANS_NONSEQ;
    dmem_hwrite = 1'b1;
    dmem_haddr  = 32'h104;
    dmem_hsize  = HSIZE_WORD;
    tick();
    dmem_htrans = HTRANS_IDLE;
    dmem_hwrite = 1'b0;
    dmem_hwdata = 32'h1234_5678;
    #4;
    check("abort_stalled", 32'(dmem_hready), 32'd0);
    rst = 1'b1;
    dmem_req_ack_stall_in = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #4;
    check("abort_rdy", 32'(dmem_hready), 32'd1);
    check("abort_hrdata", dmem_hrdata, 32'd0);
    check("abort_outs", {29'd0, ext_irq, soft_irq, print_vld}, 32'd0);
    dmem_rd_chk("abort_mem", 32'h104, 32'h7766_5544);
    imem_rd_chk("rst_keeps_mem", 32'h200, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
